// File: rtl/draw_scheduler_pkg.sv
// Shared constants for the frame draw sequencer: FSM encodings, default
// pixel-bus widths and the drawer watchdog default.
package draw_scheduler_pkg;

    localparam int unsigned DEF_NUM_SHAPES = 8;
    localparam int unsigned DEF_X_W        = 11;
    localparam int unsigned DEF_Y_W        = 11;
    localparam int unsigned DEF_COLOUR_W   = 3;
    localparam int unsigned DRAW_TIMEOUT   = 4096;
    localparam int unsigned OVR_W          = 8;

    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_SCAN    = 3'd2;
    localparam logic [2:0] ST_DRAW    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Index width able to hold 0..n inclusive (n = one past the last drawer).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Drawer handshake and pixel buses between the scheduler, its drawers and the VGA adapter.
interface draw_scheduler_if
    import draw_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SHAPES = DEF_NUM_SHAPES,
    parameter int unsigned X_W        = DEF_X_W,
    parameter int unsigned Y_W        = DEF_Y_W,
    parameter int unsigned COLOUR_W   = DEF_COLOUR_W
) ();

    logic                           clear_start;
    logic                           clear_done;
    logic [X_W-1:0]                 clear_x;
    logic [Y_W-1:0]                 clear_y;
    logic [COLOUR_W-1:0]            clear_colour;
    logic                           clear_plot;

    logic [NUM_SHAPES-1:0]          shape_start;
    logic [NUM_SHAPES-1:0]          shape_done;
    logic [NUM_SHAPES*X_W-1:0]      shape_x;
    logic [NUM_SHAPES*Y_W-1:0]      shape_y;
    logic [NUM_SHAPES*COLOUR_W-1:0] shape_colour;
    logic [NUM_SHAPES-1:0]          shape_plot;

    logic [X_W-1:0]                 vga_x;
    logic [Y_W-1:0]                 vga_y;
    logic [COLOUR_W-1:0]            vga_colour;
    logic                           vga_plot;

    modport master (
        output clear_start, shape_start, vga_x, vga_y, vga_colour, vga_plot,
        input  clear_done, clear_x, clear_y, clear_colour, clear_plot,
        input  shape_done, shape_x, shape_y, shape_colour, shape_plot
    );

    modport slave (
        input  clear_start, shape_start, vga_x, vga_y, vga_colour, vga_plot,
        output clear_done, clear_x, clear_y, clear_colour, clear_plot,
        output shape_done, shape_x, shape_y, shape_colour, shape_plot
    );

endinterface

// File: rtl/draw_scheduler_first_set_finder.sv
// Priority encoder: lowest set bit of vec at or above start, single cycle.
module first_set_finder #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 4
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] pos
);

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i] && (IW'(i) >= start)) begin
                found = 1'b1;
                pos   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Frame draw sequencer: clear, then each active shape in index order,
// sharing one VGA pixel port through a start/done handshake.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SHAPES = DEF_NUM_SHAPES,
    parameter int unsigned X_W        = DEF_X_W,
    parameter int unsigned Y_W        = DEF_Y_W,
    parameter int unsigned COLOUR_W   = DEF_COLOUR_W,
    parameter int unsigned TIMEOUT    = DRAW_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  frame_tick,
    input  logic [NUM_SHAPES-1:0] shape_active,
    output logic                  frame_busy,
    output logic [OVR_W-1:0]      overrun_count,
    output logic                  timeout_flag,
    draw_scheduler_if.master      bus
);

    localparam int unsigned IDX_W = idx_width(NUM_SHAPES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [STATE_W-1:0]    state, state_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [NUM_SHAPES-1:0] mask, mask_d;
    logic                  pending, pending_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [OVR_W-1:0]      overrun_d;
    logic                  timeout_d;
    logic                  busy_d;
    logic                  clear_start_q, clear_start_d;
    logic [NUM_SHAPES-1:0] shape_start_q, shape_start_d;
    logic                  sel_done, timed_out;
    logic                  scan_found;
    logic [IDX_W-1:0]      scan_pos;

    first_set_finder #(.N(NUM_SHAPES), .IW(IDX_W)) u_finder (
        .vec   (mask),
        .start (idx),
        .found (scan_found),
        .pos   (scan_pos)
    );

    // done of the drawer currently selected by idx
    always_comb begin
        sel_done = 1'b0;
        for (int i = 0; i < int'(NUM_SHAPES); i++) begin
            if (idx == IDX_W'(i)) sel_done = bus.shape_done[i];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            idx           <= '0;
            mask          <= '0;
            pending       <= 1'b0;
            cnt           <= '0;
            overrun_count <= '0;
            timeout_flag  <= 1'b0;
            frame_busy    <= 1'b0;
            clear_start_q <= 1'b0;
            shape_start_q <= '0;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            mask          <= mask_d;
            pending       <= pending_d;
            cnt           <= cnt_d;
            overrun_count <= overrun_d;
            timeout_flag  <= timeout_d;
            frame_busy    <= busy_d;
            clear_start_q <= clear_start_d;
            shape_start_q <= shape_start_d;
        end
    end

    // Starts are registered from the next state so they drop on the same edge the FSM leaves.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        mask_d    = mask;
        pending_d = pending;
        cnt_d     = '0;
        overrun_d = overrun_count;
        timeout_d = timeout_flag;
        timed_out = (cnt == CNT_W'(TIMEOUT - 1));

        if (enable && frame_tick && (state != ST_IDLE)) begin
            pending_d = 1'b1;
            if (overrun_count != {OVR_W{1'b1}}) overrun_d = overrun_count + OVR_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (enable && (frame_tick || pending)) begin
                    mask_d    = shape_active;
                    pending_d = 1'b0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (bus.clear_done) begin
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end else if (timed_out) begin
                    timeout_d = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_SCAN;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (scan_found) begin
                    idx_d   = scan_pos;
                    state_d = ST_DRAW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (sel_done) begin
                    state_d = ST_RELEASE;
                end else if (timed_out) begin
                    timeout_d = 1'b1;
                    idx_d     = idx + IDX_W'(1);
                    state_d   = ST_SCAN;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!sel_done) begin
                    idx_d   = idx + IDX_W'(1);
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
        end

        busy_d        = (state_d != ST_IDLE);
        clear_start_d = (state_d == ST_CLEAR);
        for (int i = 0; i < int'(NUM_SHAPES); i++) begin
            shape_start_d[i] = (state_d == ST_DRAW) && (idx_d == IDX_W'(i));
        end
    end

    assign bus.clear_start = clear_start_q;
    assign bus.shape_start = shape_start_q;

    // Pixel mux from registered state/idx; silent outside CLEAR and DRAW.
    always_comb begin
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        bus.vga_plot   = 1'b0;
        if (state == ST_CLEAR) begin
            bus.vga_x      = bus.clear_x;
            bus.vga_y      = bus.clear_y;
            bus.vga_colour = bus.clear_colour;
            bus.vga_plot   = bus.clear_plot;
        end else if (state == ST_DRAW) begin
            for (int i = 0; i < int'(NUM_SHAPES); i++) begin
                if (idx == IDX_W'(i)) begin
                    bus.vga_x      = bus.shape_x[i*X_W +: X_W];
                    bus.vga_y      = bus.shape_y[i*Y_W +: Y_W];
                    bus.vga_colour = bus.shape_colour[i*COLOUR_W +: COLOUR_W];
                    bus.vga_plot   = bus.shape_plot[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboarded bench for draw_scheduler: drawer models, expected start order queue,
// per-cycle mux/overlap monitor and directed frame scenarios.
module tb_draw_scheduler;

    localparam int unsigned NS = 8;
    localparam int unsigned XW = 11;
    localparam int unsigned YW = 11;
    localparam int unsigned CW = 3;
    localparam int unsigned TO = 16;
    localparam logic [7:0] EV_CLR = 8'hFF;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          frame_tick = 1'b0;
    logic [NS-1:0] shape_active = '0;
    logic          frame_busy;
    logic [7:0]    overrun_count;
    logic          timeout_flag;

    draw_scheduler_if #(.NUM_SHAPES(NS), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) bus ();

    draw_scheduler #(.NUM_SHAPES(NS), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .frame_tick    (frame_tick),
        .shape_active  (shape_active),
        .frame_busy    (frame_busy),
        .overrun_count (overrun_count),
        .timeout_flag  (timeout_flag),
        .bus           (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    bit sb_ignore = 1'b0;
    int c_lat = 10;
    int s_lat[NS];
    int c_cnt;
    int s_cnt[NS];

    // Drawer models: assert done after lat cycles of start (lat 0 = never), hold until start drops.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            c_cnt <= 0;
            bus.clear_done <= 1'b0;
            for (int i = 0; i < int'(NS); i++) begin
                s_cnt[i] <= 0;
                bus.shape_done[i] <= 1'b0;
            end
        end else begin
            if (!bus.clear_start) begin
                c_cnt <= 0;
                bus.clear_done <= 1'b0;
            end else if (!bus.clear_done) begin
                c_cnt <= c_cnt + 1;
                if (c_cnt + 1 == c_lat) bus.clear_done <= 1'b1;
            end
            for (int i = 0; i < int'(NS); i++) begin
                if (!bus.shape_start[i]) begin
                    s_cnt[i] <= 0;
                    bus.shape_done[i] <= 1'b0;
                end else if (!bus.shape_done[i]) begin
                    s_cnt[i] <= s_cnt[i] + 1;
                    if (s_cnt[i] + 1 == s_lat[i]) bus.shape_done[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.clear_x      = XW'(5);
    assign bus.clear_y      = YW'(6);
    assign bus.clear_colour = CW'(7);
    assign bus.clear_plot   = c_cnt[0];

    for (genvar g = 0; g < int'(NS); g++) begin : g_pix
        assign bus.shape_x[g*XW +: XW]      = XW'(100 + 3*g);
        assign bus.shape_y[g*YW +: YW]      = YW'(200 + g);
        assign bus.shape_colour[g*CW +: CW] = CW'(g);
        assign bus.shape_plot[g]            = s_cnt[g][0];
    end

    // Monitor: start order against the queue, no overlapping starts, VGA mux contents.
    logic [NS:0] prev_st = '0;
    always @(negedge clock) begin
        logic [NS:0] cur;
        logic [NS:0] rise;
        logic [XW+YW+CW:0] ev, av;
        logic [7:0] got, want;
        cur  = {bus.clear_start, bus.shape_start};
        rise = cur & ~prev_st;
        prev_st <= cur;

        total++;
        if ($countones(cur) > 1) begin
            bad++;
            $display("FAIL start_overlap: got starts=%b want at most one set", cur);
        end

        ev = '0;
        if (bus.clear_start) ev = {XW'(5), YW'(6), CW'(7), bus.clear_plot};
        for (int i = 0; i < int'(NS); i++) begin
            if (bus.shape_start[i]) ev = {XW'(100 + 3*i), YW'(200 + i), CW'(i), bus.shape_plot[i]};
        end
        av = {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot};
        total++;
        if (av !== ev) begin
            bad++;
            $display("FAIL vga_mux: got %h want %h", av, ev);
        end

        if (!sb_ignore) begin
            for (int i = 0; i <= int'(NS); i++) begin
                if (rise[i]) begin
                    got = (i == int'(NS)) ? EV_CLR : 8'(i);
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL start_order: got drawer %0d want none", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL start_order: got drawer %0d want %0d", got, want);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (frame_busy && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(frame_busy), 32'd0);
    endtask

    task automatic wait_shape(input int i, input int maxc);
        int n = 0;
        while (!bus.shape_start[i] && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk("shape_start_seen", 32'(bus.shape_start[i]), 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < int'(NS); i++) s_lat[i] = 10;

        // reset values
        repeat (2) @(negedge clock);
        chk("rst_clear_start", 32'(bus.clear_start), 0);
        chk("rst_shape_start", 32'(bus.shape_start), 0);
        chk("rst_vga_plot", 32'(bus.vga_plot), 0);
        chk("rst_vga_x", 32'(bus.vga_x), 0);
        chk("rst_busy", 32'(frame_busy), 0);
        chk("rst_overrun", 32'(overrun_count), 0);
        chk("rst_timeout", 32'(timeout_flag), 0);
        resetn = 1'b1;
        enable = 1'b1;

        // mask 0000_0101: clear, shape 0, shape 2
        shape_active = 8'b0000_0101;
        exp_q.push_back(EV_CLR); exp_q.push_back(8'd0); exp_q.push_back(8'd2);
        tick();
        chk("tick_to_clear_start", 32'(bus.clear_start), 1);
        chk("busy_in_frame", 32'(frame_busy), 1);
        shape_active = 8'hFF;
        wait_idle("frame_a_end", 200);
        chk("frame_a_queue", 32'(exp_q.size()), 0);

        // empty mask: clear only
        shape_active = 8'h00;
        exp_q.push_back(EV_CLR);
        tick();
        wait_idle("frame_b_end", 100);
        chk("frame_b_queue", 32'(exp_q.size()), 0);

        // overrun tick during shape 0, pending frame follows IDLE by one cycle
        shape_active = 8'b0000_0001;
        exp_q.push_back(EV_CLR); exp_q.push_back(8'd0);
        exp_q.push_back(EV_CLR); exp_q.push_back(8'd0);
        tick();
        wait_shape(0, 100);
        tick();
        chk("overrun_one", 32'(overrun_count), 1);
        wait_idle("overrun_first_end", 100);
        @(negedge clock);
        chk("pending_restart_busy", 32'(frame_busy), 1);
        chk("pending_restart_clear", 32'(bus.clear_start), 1);
        wait_idle("overrun_second_end", 100);
        chk("overrun_queue", 32'(exp_q.size()), 0);
        chk("overrun_hold", 32'(overrun_count), 1);

        // shape 1 never finishes: watchdog skips it after TO cycles
        s_lat[1] = 0;
        shape_active = 8'b0000_0110;
        exp_q.push_back(EV_CLR); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
        tick();
        chk("timeout_clear_before", 32'(timeout_flag), 0);
        wait_shape(1, 100);
        n = 0;
        while (bus.shape_start[1] && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("timeout_start_len", 32'(n), 32'(TO));
        chk("timeout_flag_set", 32'(timeout_flag), 1);
        wait_idle("timeout_frame_end", 100);
        chk("timeout_queue", 32'(exp_q.size()), 0);
        s_lat[1] = 10;

        // enable dropped during DRAW
        shape_active = 8'b0000_0001;
        exp_q.push_back(EV_CLR); exp_q.push_back(8'd0);
        tick();
        wait_shape(0, 100);
        repeat (3) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        chk("dis_shape_start", 32'(bus.shape_start), 0);
        chk("dis_clear_start", 32'(bus.clear_start), 0);
        chk("dis_busy", 32'(frame_busy), 0);
        chk("dis_vga_plot", 32'(bus.vga_plot), 0);
        tick();
        chk("dis_tick_ignored", 32'(frame_busy), 0);
        repeat (3) @(negedge clock);
        enable = 1'b1;
        repeat (3) @(negedge clock);
        chk("dis_no_pending", 32'(frame_busy), 0);
        chk("dis_overrun_hold", 32'(overrun_count), 1);
        chk("dis_queue", 32'(exp_q.size()), 0);

        // overrun saturation under continuous ticks
        sb_ignore = 1'b1;
        shape_active = 8'h00;
        @(negedge clock);
        frame_tick = 1'b1;
        repeat (400) @(negedge clock);
        frame_tick = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clock);
        sb_ignore = 1'b0;
        chk("overrun_saturate", 32'(overrun_count), 255);
        chk("burst_idle", 32'(frame_busy), 0);
        enable = 1'b1;

        // asynchronous reset mid-CLEAR
        exp_q.push_back(EV_CLR);
        tick();
        repeat (2) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("arst_clear_start", 32'(bus.clear_start), 0);
        chk("arst_busy", 32'(frame_busy), 0);
        chk("arst_overrun", 32'(overrun_count), 0);
        chk("arst_timeout", 32'(timeout_flag), 0);
        chk("arst_vga_plot", 32'(bus.vga_plot), 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        chk("arst_no_resume_busy", 32'(frame_busy), 0);
        chk("arst_no_resume_start", 32'(bus.clear_start), 0);
        chk("arst_queue", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
